// File: rtl/noc_pkg.sv
// noc_pkg: link-level constants and types shared by the NoC sender,
// input buffer and router stages.
//   FLIT_W            - link data width in bits
//   flit_t            - one flit on the link
//   DEFAULT_BUF_DEPTH - receive buffer entries, and so the sender's initial credit count
package noc_pkg;

   localparam int unsigned FLIT_W            = 16;
   localparam int unsigned DEFAULT_BUF_DEPTH = 4;

   typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: first-word-fall-through FIFO used as NoC link receive storage.
//   clk, rst : clock and synchronous active-high reset
//   push     : write din at the tail; the caller guarantees !full || pop
//   pop      : drop the head entry; the caller guarantees !empty
//   din      : write data
//   dout     : head entry, or zero when empty
//   count    : occupancy, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
module noc_fifo
   import noc_pkg::*;
#(
   parameter int unsigned W     = FLIT_W,
   parameter int unsigned DEPTH = DEFAULT_BUF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Storage holds no reset: after reset the pointers and count mark every
   // entry invalid, and dout is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap modulo DEPTH by overflowing.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      empty = (count == '0);
      full  = (count == CW'(DEPTH));
      dout  = empty ? '0 : mem[rd_ptr];
   end

endmodule

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: receive side of a credit-based NoC link.
//   clk, rst  : clock and synchronous active-high reset
//   in_enable : flit valid from the upstream sender
//   in_data   : flit payload from the upstream sender
//   in_credit : one-cycle credit pulse per flit that left the buffer
//   out_valid : buffer holds at least one flit
//   out_data  : head flit, zero when empty
//   out_ready : downstream takes the head flit this cycle
//   count     : buffer occupancy
//   overflow  : sticky; a flit arrived while full with no pop in that cycle
module noc_input_buffer #(
   parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
   parameter int unsigned DEPTH  = noc_pkg::DEFAULT_BUF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_enable,
   input  logic [FLIT_W-1:0]          in_data,
   output logic                       in_credit,
   output logic                       out_valid,
   output logic [FLIT_W-1:0]          out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   logic push;
   logic pop;
   logic full;
   logic empty;

   noc_fifo #(
      .W     (FLIT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (in_data),
      .dout  (out_data),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // A pop in the same cycle frees the head slot, so a write while full is
   // still accepted as long as the head leaves.
   always_comb begin
      out_valid = !empty;
      pop       = out_valid && out_ready;
      push      = in_enable && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_credit <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         in_credit <= pop;
         if (in_enable && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_noc_input_buffer.sv
module tb_noc_input_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_enable = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_credit;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready = 1'b0;
   logic [2:0]  count;
   logic        overflow;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   noc_input_buffer #(
      .FLIT_W (16),
      .DEPTH  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_enable (in_enable),
      .in_data   (in_data),
      .in_credit (in_credit),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] data;
      logic        rdy;
      int unsigned rep;
      logic        v;
      logic [15:0] d;
      logic [2:0]  c;
      logic        cr;
      logic        ov;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic en, input logic [15:0] data,
                      input logic rdy, input int unsigned rep,
                      input logic v, input logic [15:0] d, input logic [2:0] c,
                      input logic cr, input logic ov);
      vec_t x;
      x.rst = r; x.en = en; x.data = data; x.rdy = rdy; x.rep = rep;
      x.v = v; x.d = d; x.c = c; x.cr = cr; x.ov = ov;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input int unsigned idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int unsigned idx, input logic v, input logic [15:0] d,
                            input logic [2:0] c, input logic cr, input logic ov);
      chk("out_valid", idx, {31'b0, out_valid}, {31'b0, v});
      chk("out_data",  idx, {16'b0, out_data},  {16'b0, d});
      chk("count",     idx, {29'b0, count},     {29'b0, c});
      chk("in_credit", idx, {31'b0, in_credit}, {31'b0, cr});
      chk("overflow",  idx, {31'b0, overflow},  {31'b0, ov});
   endtask

   // Inputs are driven and outputs sampled 1 time unit after each posedge.
   task automatic step(input logic r, input logic en, input logic [15:0] data,
                       input logic rdy);
      rst = r; in_enable = en; in_data = data; out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned credits;

      //   rst en data     rdy rep  v  d        c  cr ov
      add(1, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 0); // reset
      // fill with out_ready low
      add(0, 1, 16'hA001, 0, 1,   1, 16'hA001, 1, 0, 0);
      add(0, 1, 16'hA002, 0, 1,   1, 16'hA001, 2, 0, 0);
      add(0, 1, 16'hA003, 0, 1,   1, 16'hA001, 3, 0, 0);
      add(0, 1, 16'hA004, 0, 1,   1, 16'hA001, 4, 0, 0);
      add(0, 0, 16'h0000, 0, 1,   1, 16'hA001, 4, 0, 0);
      // drain; credit follows each pop by one cycle
      add(0, 0, 16'h0000, 1, 1,   1, 16'hA002, 3, 1, 0);
      add(0, 0, 16'h0000, 1, 1,   1, 16'hA003, 2, 1, 0);
      add(0, 0, 16'h0000, 1, 1,   1, 16'hA004, 1, 1, 0);
      add(0, 0, 16'h0000, 1, 1,   0, 16'h0000, 0, 1, 0);
      // empty with out_ready high: nothing happens
      add(0, 0, 16'h0000, 1, 2,   0, 16'h0000, 0, 0, 0);
      // refill, then push+pop while full
      add(0, 1, 16'hB001, 0, 1,   1, 16'hB001, 1, 0, 0);
      add(0, 1, 16'hB002, 0, 1,   1, 16'hB001, 2, 0, 0);
      add(0, 1, 16'hB003, 0, 1,   1, 16'hB001, 3, 0, 0);
      add(0, 1, 16'hB004, 0, 1,   1, 16'hB001, 4, 0, 0);
      add(0, 1, 16'hBEEF, 1, 1,   1, 16'hB002, 4, 1, 0);
      add(0, 0, 16'h0000, 0, 1,   1, 16'hB002, 4, 0, 0);
      // overflow: DEAD dropped, contents intact
      add(0, 1, 16'hDEAD, 0, 1,   1, 16'hB002, 4, 0, 1);
      add(0, 0, 16'h0000, 1, 1,   1, 16'hB003, 3, 1, 1);
      add(0, 0, 16'h0000, 1, 1,   1, 16'hB004, 2, 1, 1);
      add(0, 0, 16'h0000, 1, 1,   1, 16'hBEEF, 1, 1, 1);
      add(0, 0, 16'h0000, 1, 1,   0, 16'h0000, 0, 1, 1);
      add(0, 0, 16'h0000, 0, 20,  0, 16'h0000, 0, 0, 1); // sticky
      add(1, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 0); // clears overflow
      // reset while count=3 and popping
      add(0, 1, 16'hC001, 0, 1,   1, 16'hC001, 1, 0, 0);
      add(0, 1, 16'hC002, 0, 1,   1, 16'hC001, 2, 0, 0);
      add(0, 1, 16'hC003, 0, 1,   1, 16'hC001, 3, 0, 0);
      add(0, 1, 16'hC004, 1, 1,   1, 16'hC002, 3, 1, 0);
      add(1, 1, 16'hC005, 1, 1,   0, 16'h0000, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 2,   0, 16'h0000, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         for (int unsigned r = 0; r < vecs[i].rep; r++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].data, vecs[i].rdy);
            check_all(i, vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].cr, vecs[i].ov);
         end
      end

      // Back-to-back stream of 10 flits with out_ready held high: the pointers
      // wrap twice, occupancy stays at 1 and every flit earns one credit.
      credits = 0;
      for (int unsigned k = 0; k < 10; k++) begin
         step(0, 1, 16'(k), 1);
         if (in_credit) credits++;
         check_all(100 + k, 1'b1, 16'(k), 3'd1, (k != 0), 1'b0);
      end
      step(0, 0, 16'h0000, 1);
      if (in_credit) credits++;
      check_all(110, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0);
      for (int unsigned k = 0; k < 3; k++) begin
         step(0, 0, 16'h0000, 1);
         if (in_credit) credits++;
         check_all(111 + k, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
      end
      chk("stream_credits", 200, credits, 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
